// File: rtl/ufm_stream_seq.sv
// Multi-region UFM dump sequencer: fetches pages through the reader, buffers 16 bytes,
// and streams only the in-range bytes on a valid/ready byte interface.
module ufm_stream_seq #(
  parameter int                         NUM_REGIONS  = 2,
  parameter logic [NUM_REGIONS*15-1:0]  REGION_START = {15'd32672, 15'd32643},
  parameter logic [NUM_REGIONS*15-1:0]  REGION_END   = {15'd32735, 15'd32645},
  parameter bit                         REPEAT       = 1'b1,
  parameter int                         GAP_CYCLES   = 12090000,
  parameter int                         GAP_W        = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        go,
  input  logic        abort,
  output logic        rd_start,
  output logic [10:0] rd_page,
  input  logic        rd_ready,
  input  logic [7:0]  rd_data,
  input  logic        rd_data_stb,
  output logic [7:0]  out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        busy,
  output logic        done,
  output logic [2:0]  cur_region,
  output logic [14:0] cur_addr
);

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_FILL, S_DRAIN, S_GAP} state_e;

  localparam logic [GAP_W-1:0] GAP_LAST = (GAP_CYCLES == 0) ? '0 : GAP_W'(GAP_CYCLES - 1);

  state_e            state_q, state_d;
  logic [2:0]        region_q, region_d;
  logic [10:0]       page_q, page_d;
  logic              first_q, first_d;
  logic [3:0]        fidx_q, fidx_d;
  logic [3:0]        bidx_q, bidx_d;
  logic              out_valid_q, out_valid_d;
  logic              rd_start_q, rd_start_d;
  logic              done_q, done_d;
  logic [GAP_W-1:0]  gap_q, gap_d;
  logic [7:0]        buf_q [16];

  logic [3:0]  start_lo;
  logic [14:0] cur_end;
  logic        last_page;
  logic [3:0]  lo, hi;
  logic [3:0]  search_base;
  logic        nxt_found;
  logic [2:0]  nxt_region;
  logic [10:0] nxt_page;
  logic        enter, end_pass, xfer;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      region_q    <= '0;
      page_q      <= '0;
      first_q     <= 1'b0;
      fidx_q      <= '0;
      bidx_q      <= '0;
      out_valid_q <= 1'b0;
      rd_start_q  <= 1'b0;
      done_q      <= 1'b0;
      gap_q       <= '0;
    end else begin
      state_q     <= state_d;
      region_q    <= region_d;
      page_q      <= page_d;
      first_q     <= first_d;
      fidx_q      <= fidx_d;
      bidx_q      <= bidx_d;
      out_valid_q <= out_valid_d;
      rd_start_q  <= rd_start_d;
      done_q      <= done_d;
      gap_q       <= gap_d;
    end
  end

  always_ff @(posedge clk) begin
    if (state_q == S_FILL && rd_data_stb) buf_q[fidx_q] <= rd_data;
  end

  // Byte window of the page currently held in the buffer.
  always_comb begin
    start_lo = '0;
    cur_end  = '0;
    for (int i = 0; i < NUM_REGIONS; i++) begin
      if (region_q == 3'(i)) begin
        start_lo = REGION_START[15*i +: 4];
        cur_end  = REGION_END[15*i +: 15];
      end
    end
    last_page = (page_q == cur_end[14:4]);
    lo = first_q ? start_lo : 4'd0;
    hi = last_page ? cur_end[3:0] : 4'hf;
  end

  // Next non-empty region: from 0 at pass start, else after the current one.
  always_comb begin
    search_base = (state_q == S_DRAIN) ? ({1'b0, region_q} + 4'd1) : 4'd0;
    nxt_found   = 1'b0;
    nxt_region  = '0;
    nxt_page    = '0;
    for (int i = 0; i < NUM_REGIONS; i++) begin
      if (!nxt_found && 4'(i) >= search_base &&
          REGION_END[15*i +: 15] >= REGION_START[15*i +: 15]) begin
        nxt_found  = 1'b1;
        nxt_region = 3'(i);
        nxt_page   = REGION_START[15*i+4 +: 11];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    region_d    = region_q;
    page_d      = page_q;
    first_d     = first_q;
    fidx_d      = fidx_q;
    bidx_d      = bidx_q;
    out_valid_d = out_valid_q;
    rd_start_d  = 1'b0;
    done_d      = 1'b0;
    gap_d       = gap_q;
    enter       = 1'b0;
    end_pass    = 1'b0;
    xfer        = out_valid_q && out_ready;

    case (state_q)
      S_IDLE:  if (go && !abort) enter = 1'b1;
      S_FETCH: if (rd_ready) begin
        rd_start_d = 1'b1;
        fidx_d     = '0;
        state_d    = S_FILL;
      end
      S_FILL:  if (rd_data_stb) begin
        fidx_d = fidx_q + 4'd1;
        if (fidx_q == 4'hf) begin
          state_d = S_DRAIN;
          bidx_d  = lo;
        end
      end
      S_DRAIN: begin
        if (!out_valid_q) begin
          out_valid_d = 1'b1;
        end else if (xfer) begin
          if (bidx_q == hi) begin
            out_valid_d = 1'b0;
            if (!last_page) begin
              page_d  = page_q + 11'd1;
              first_d = 1'b0;
              state_d = S_FETCH;
            end else begin
              enter = 1'b1;
            end
          end else begin
            bidx_d = bidx_q + 4'd1;
          end
        end
      end
      S_GAP:   if (gap_q == GAP_LAST) enter = 1'b1;
               else gap_d = gap_q + 1'b1;
      default: state_d = S_IDLE;
    endcase

    if (enter) begin
      if (nxt_found) begin
        region_d = nxt_region;
        page_d   = nxt_page;
        first_d  = 1'b1;
        state_d  = S_FETCH;
      end else begin
        end_pass = 1'b1;
      end
    end

    if (end_pass) begin
      if (REPEAT) begin
        state_d = S_GAP;
        gap_d   = '0;
      end else begin
        state_d = S_IDLE;
        done_d  = 1'b1;
      end
    end

    // Abort wins over everything; a handshake in this cycle has already completed.
    if (abort && state_q != S_IDLE) begin
      state_d     = S_IDLE;
      out_valid_d = 1'b0;
      rd_start_d  = 1'b0;
      done_d      = 1'b1;
    end
  end

  always_comb begin
    busy       = (state_q != S_IDLE);
    out_valid  = out_valid_q;
    out_data   = out_valid_q ? buf_q[bidx_q] : 8'd0;
    cur_addr   = out_valid_q ? {page_q, bidx_q} : 15'd0;
    rd_start   = rd_start_q;
    rd_page    = page_q;
    done       = done_q;
    cur_region = region_q;
  end

endmodule
